// File: rtl/traffic_light_multi.sv
// Round-robin traffic light controller for NUM_DIR approaches. It skips approaches
// that have no demand and supports a maintenance flashing-yellow mode.
module traffic_light_multi #(
  parameter int NUM_DIR  = 2,
  parameter int TICK_DIV = 100000000,
  parameter int GREEN_T  = 3,
  parameter int YELLOW_T = 1,
  parameter int ALLRED_T = 1,
  parameter int TW       = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       sensor,
  input  logic [NUM_DIR-1:0]         demand,
  input  logic                       flash,
  output logic [NUM_DIR-1:0]         red,
  output logic [NUM_DIR-1:0]         yellow,
  output logic [NUM_DIR-1:0]         green,
  output logic [$clog2(NUM_DIR)-1:0] active_dir,
  output logic [TW-1:0]              remaining,
  output logic                       tick
);

  localparam int AW = $clog2(NUM_DIR);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] G_LOAD  = TW'(GREEN_T);
  localparam logic [TW-1:0] Y_LOAD  = TW'(YELLOW_T);
  localparam logic [TW-1:0] AR_LOAD = TW'(ALLRED_T);

  typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED, S_FLASH} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] active_dir_nxt;
  logic [AW-1:0] next_dir, next_dir_nxt;
  logic [TW-1:0] remaining_nxt;
  logic          blink, blink_nxt;
  logic [PW-1:0] prescaler, prescaler_nxt, prescaler_step;

  logic          found;
  logic [AW-1:0] found_dir;
  logic [AW-1:0] cand;
  int            search_idx;

  logic [NUM_DIR-1:0] dir_mask;

  assign tick           = en && (prescaler == PRE_MAX);
  assign prescaler_step = (prescaler == PRE_MAX) ? '0 : prescaler + PW'(1);
  assign dir_mask       = NUM_DIR'(1) << active_dir;

  // Walk the search order backwards so that the nearest requesting approach wins.
  always_comb begin
    found      = 1'b0;
    found_dir  = '0;
    cand       = '0;
    search_idx = 0;
    for (int k = NUM_DIR - 1; k >= 1; k--) begin
      search_idx = int'(active_dir) + k;
      if (search_idx >= NUM_DIR) search_idx = search_idx - NUM_DIR;
      cand = AW'(search_idx);
      if (demand[cand]) begin
        found     = 1'b1;
        found_dir = cand;
      end
    end
  end

  always_comb begin
    // NOTE: each signal in this block gets a default value first, so no latches are inferred.
    state_nxt      = state;
    active_dir_nxt = active_dir;
    next_dir_nxt   = next_dir;
    remaining_nxt  = remaining;
    blink_nxt      = blink;
    prescaler_nxt  = prescaler;

    if (!sensor) begin
      state_nxt      = S_GREEN;
      active_dir_nxt = '0;
      next_dir_nxt   = '0;
      remaining_nxt  = G_LOAD;
      blink_nxt      = 1'b0;
      prescaler_nxt  = '0;
    end else if (flash) begin
      if (state != S_FLASH) begin
        state_nxt     = S_FLASH;
        blink_nxt     = 1'b0;
        remaining_nxt = '0;
        prescaler_nxt = '0;
      end else if (en) begin
        prescaler_nxt = prescaler_step;
        if (tick) blink_nxt = ~blink;
      end
    end else if (state == S_FLASH) begin
      // Leaving flash mode behaves like the end of a yellow phase that leads back to approach 0.
      next_dir_nxt  = '0;
      blink_nxt     = 1'b0;
      prescaler_nxt = '0;
      if (ALLRED_T != 0) begin
        state_nxt     = S_ALLRED;
        remaining_nxt = AR_LOAD;
      end else begin
        state_nxt      = S_GREEN;
        active_dir_nxt = '0;
        remaining_nxt  = G_LOAD;
      end
    end else if (en) begin
      prescaler_nxt = prescaler_step;
      if (tick) begin
        if (remaining != TW'(1)) begin
          remaining_nxt = remaining - TW'(1);
        end else begin
          case (state)
            S_GREEN: begin
              if (found) begin
                next_dir_nxt  = found_dir;
                state_nxt     = S_YELLOW;
                remaining_nxt = Y_LOAD;
              end else begin
                remaining_nxt = G_LOAD;
              end
            end
            S_YELLOW: begin
              if (ALLRED_T != 0) begin
                state_nxt     = S_ALLRED;
                remaining_nxt = AR_LOAD;
              end else begin
                state_nxt      = S_GREEN;
                active_dir_nxt = next_dir;
                remaining_nxt  = G_LOAD;
              end
            end
            S_ALLRED: begin
              state_nxt      = S_GREEN;
              active_dir_nxt = next_dir;
              remaining_nxt  = G_LOAD;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments, so all registers update together.
    if (reset) begin
      state      <= S_GREEN;
      active_dir <= '0;
      next_dir   <= '0;
      remaining  <= G_LOAD;
      blink      <= 1'b0;
      prescaler  <= '0;
    end else begin
      state      <= state_nxt;
      active_dir <= active_dir_nxt;
      next_dir   <= next_dir_nxt;
      remaining  <= remaining_nxt;
      blink      <= blink_nxt;
      prescaler  <= prescaler_nxt;
    end
  end

  always_comb begin
    red    = '0;
    yellow = '0;
    green  = '0;
    case (state)
      S_GREEN: begin
        green = dir_mask;
        red   = ~dir_mask;
      end
      S_YELLOW: begin
        yellow = dir_mask;
        red    = ~dir_mask;
      end
      S_ALLRED: red    = '1;
      S_FLASH:  yellow = {NUM_DIR{blink}};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_multi.sv
// Directed bench for traffic_light_multi: NUM_DIR=4, TICK_DIV=4, G=3, Y=1, AR=1,
// plus a second instance with AR=0 for the direct flash-exit path.
module tb_traffic_light_multi;

  logic       clk = 1'b0;
  logic       reset, en, sensor, flash;
  logic [3:0] demand;

  logic [3:0] red_a, yellow_a, green_a;
  logic [1:0] dir_a;
  logic [7:0] rem_a;
  logic       tick_a;

  logic [3:0] red_b, yellow_b, green_b;
  logic [1:0] dir_b;
  logic [7:0] rem_b;
  logic       tick_b;

  int total = 0;
  int bad   = 0;

  traffic_light_multi #(
    .NUM_DIR(4), .TICK_DIV(4), .GREEN_T(3), .YELLOW_T(1), .ALLRED_T(1), .TW(8)
  ) dut_a (
    .clk(clk), .reset(reset), .en(en), .sensor(sensor), .demand(demand), .flash(flash),
    .red(red_a), .yellow(yellow_a), .green(green_a), .active_dir(dir_a),
    .remaining(rem_a), .tick(tick_a)
  );

  traffic_light_multi #(
    .NUM_DIR(4), .TICK_DIV(4), .GREEN_T(3), .YELLOW_T(1), .ALLRED_T(0), .TW(8)
  ) dut_b (
    .clk(clk), .reset(reset), .en(en), .sensor(sensor), .demand(demand), .flash(flash),
    .red(red_b), .yellow(yellow_b), .green(green_b), .active_dir(dir_b),
    .remaining(rem_b), .tick(tick_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [22:0] got, exp;
    en = 1'b1; sensor = 1'b1; flash = 1'b0; demand = 4'b1111;
    do_reset();
    got = {red_a, yellow_a, green_a, rem_a, dir_a, tick_a};
    exp = {4'b1110, 4'b0000, 4'b0001, 8'd3, 2'd0, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", got, exp);
    end
  endtask

  task automatic test_full_cycle();
    logic [22:0] got, exp;
    logic [11:0] exp_l;
    logic [7:0]  exp_r;
    logic [1:0]  exp_d;
    demand = 4'b1111;
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      if (k < 12) begin
        exp_l = {4'b1110, 4'b0000, 4'b0001}; exp_r = 8'(3 - k / 4); exp_d = 2'd0;
      end else if (k < 16) begin
        exp_l = {4'b1110, 4'b0001, 4'b0000}; exp_r = 8'd1; exp_d = 2'd0;
      end else if (k < 20) begin
        exp_l = {4'b1111, 4'b0000, 4'b0000}; exp_r = 8'd1; exp_d = 2'd0;
      end else begin
        exp_l = {4'b1101, 4'b0000, 4'b0010}; exp_r = 8'd3; exp_d = 2'd1;
      end
      got = {red_a, yellow_a, green_a, rem_a, dir_a, tick_a};
      exp = {exp_l, exp_r, exp_d, (k % 4 == 3)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL full_cycle k=%0d got=%h want=%h", k, got, exp);
      end
      if (k == 16) begin
        total++;
        if ({green_b, rem_b, dir_b} !== {4'b0010, 8'd3, 2'd1}) begin
          bad++;
          $display("FAIL full_cycle_noallred got=%h want=%h", {green_b, rem_b, dir_b},
                   {4'b0010, 8'd3, 2'd1});
        end
      end
      step(1);
    end
  endtask

  task automatic test_extension();
    logic [15:0] got, exp;
    demand = 4'b0001;
    do_reset();
    for (int k = 0; k <= 40; k++) begin
      got = {yellow_a, green_a, rem_a};
      exp = {4'b0000, 4'b0001, 8'(3 - (k / 4) % 3)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL extension k=%0d got=%h want=%h", k, got, exp);
      end
      step(1);
    end
  endtask

  task automatic test_skip_wrap();
    logic [13:0] got, exp;
    logic        chk;
    demand = 4'b1000;
    do_reset();
    for (int k = 0; k <= 40; k++) begin
      chk = 1'b1;
      exp = '0;
      case (k)
        12: exp = {4'b1110, 4'b0001, 4'b0000, 2'd0};
        16: exp = {4'b1111, 4'b0000, 4'b0000, 2'd0};
        20: exp = {4'b0111, 4'b0000, 4'b1000, 2'd3};
        32: exp = {4'b0111, 4'b1000, 4'b0000, 2'd3};
        36: exp = {4'b1111, 4'b0000, 4'b0000, 2'd3};
        40: exp = {4'b1110, 4'b0000, 4'b0001, 2'd0};
        default: chk = 1'b0;
      endcase
      if (chk) begin
        got = {red_a, yellow_a, green_a, dir_a};
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL skip_wrap k=%0d got=%h want=%h", k, got, exp);
        end
      end
      if (k == 20) demand = 4'b0001;
      step(1);
    end
  endtask

  task automatic test_sensor_hold();
    logic [22:0] got, exp;
    demand = 4'b1111;
    do_reset();
    step(33);
    total++;
    if ({red_a, yellow_a, green_a, dir_a} !== {4'b1101, 4'b0010, 4'b0000, 2'd1}) begin
      bad++;
      $display("FAIL sensor_pre_yellow got=%h want=%h", {red_a, yellow_a, green_a, dir_a},
               {4'b1101, 4'b0010, 4'b0000, 2'd1});
    end
    sensor = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      step(1);
      got = {red_a, yellow_a, green_a, rem_a, dir_a, tick_a};
      exp = {4'b1110, 4'b0000, 4'b0001, 8'd3, 2'd0, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL sensor_hold j=%0d got=%h want=%h", j, got, exp);
      end
    end
    sensor = 1'b1;
    for (int j = 0; j <= 12; j++) begin
      got = {red_a, yellow_a, green_a, rem_a, dir_a, tick_a};
      if (j < 12) exp = {4'b1110, 4'b0000, 4'b0001, 8'(3 - j / 4), 2'd0, (j % 4 == 3)};
      else        exp = {4'b1110, 4'b0001, 4'b0000, 8'd1, 2'd0, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL sensor_release j=%0d got=%h want=%h", j, got, exp);
      end
      step(1);
    end
  endtask

  task automatic test_flash();
    logic [19:0] got, exp;
    logic [3:0]  blink_v;
    demand = 4'b1111;
    do_reset();
    step(5);
    flash = 1'b1;
    step(1);
    for (int j = 0; j < 16; j++) begin
      blink_v = ((j / 4) % 2 == 1) ? 4'b1111 : 4'b0000;
      got = {red_a, yellow_a, green_a, rem_a};
      exp = {4'b0000, blink_v, 4'b0000, 8'd0};
      total++;
      if (got !== exp || yellow_b !== blink_v) begin
        bad++;
        $display("FAIL flash j=%0d got=%h want=%h yellow_b=%h", j, got, exp, yellow_b);
      end
      step(1);
    end
    flash = 1'b0;
    step(1);
    for (int j = 0; j <= 4; j++) begin
      got = {red_a, yellow_a, green_a, rem_a};
      if (j < 4) exp = {4'b1111, 4'b0000, 4'b0000, 8'd1};
      else       exp = {4'b1110, 4'b0000, 4'b0001, 8'd3};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL flash_exit j=%0d got=%h want=%h", j, got, exp);
      end
      if (j == 0 || j == 4) begin
        total++;
        if ({green_b, rem_b, dir_b} !== {4'b0001, (j == 0) ? 8'd3 : 8'd2, 2'd0}) begin
          bad++;
          $display("FAIL flash_exit_noallred j=%0d got=%h", j, {green_b, rem_b, dir_b});
        end
      end
      step(1);
    end
  endtask

  task automatic test_freeze();
    logic [20:0] got, exp;
    demand = 4'b1111;
    do_reset();
    step(5);
    en = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      step(1);
      got = {red_a, yellow_a, green_a, rem_a, tick_a};
      exp = {4'b1110, 4'b0000, 4'b0001, 8'd2, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL freeze j=%0d got=%h want=%h", j, got, exp);
      end
    end
    en = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      step(1);
      got = {red_a, yellow_a, green_a, rem_a, tick_a};
      exp = {4'b1110, 4'b0000, 4'b0001, (r == 3) ? 8'd1 : 8'd2, (r == 2)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL resume r=%0d got=%h want=%h", r, got, exp);
      end
    end
  endtask

  task automatic test_priority();
    logic [21:0] got, exp;
    demand = 4'b1111;
    do_reset();
    step(13);
    reset = 1'b1; sensor = 1'b0; flash = 1'b1;
    step(1);
    got = {red_a, yellow_a, green_a, rem_a, dir_a};
    exp = {4'b1110, 4'b0000, 4'b0001, 8'd3, 2'd0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL prio_reset got=%h want=%h", got, exp);
    end
    reset = 1'b0;
    step(2);
    got = {red_a, yellow_a, green_a, rem_a, dir_a};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL prio_sensor_over_flash got=%h want=%h", got, exp);
    end
    sensor = 1'b1;
    step(1);
    got = {red_a, yellow_a, green_a, rem_a, dir_a};
    exp = {4'b0000, 4'b0000, 4'b0000, 8'd0, 2'd0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL prio_flash_entry got=%h want=%h", got, exp);
    end
    flash = 1'b0;
    step(2);
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; sensor = 1'b1; flash = 1'b0; demand = 4'b1111;
    @(negedge clk);
    test_reset();
    test_full_cycle();
    test_extension();
    test_skip_wrap();
    test_sensor_hold();
    test_flash();
    test_freeze();
    test_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
